fp_add_pipe: RTL
================

Name: fp_add_pipe

Overview:
- Parametrised, fully pipelined IEEE-754 binary floating-point adder/subtractor for the FPU datapath; next generation of the single-precision adder.
- Adds generic exponent/fraction widths, an add/subtract op, full subnormal support, and a valid/ready stream handshake with back-pressure.
- A tag is carried through so the issue logic can match results to requests.
- Sits between the FPU operand-issue stage and the result writeback arbiter.

Parameters:
- EXP_W, 8, exponent field width (>=4)
- FRAC_W, 23, stored fraction width (>=4); word width W = 1+EXP_W+FRAC_W
- TAG_W, 4, width of the opaque request tag passed through

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  adder accepts operands this cycle
- in_a  in  W  operand A
- in_b  in  W  operand B
- sub  in  1  1: compute A-B (B sign inverted); 0: A+B
- round_m  in  3  rounding mode: 000 RNE, 001 RZ, 010 RD, 011 RU, 100 RNA; 101-111 treated as RNE
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  W  result
- out_tag  out  TAG_W  tag of this result
- inv  out  1  invalid-operation flag
- ov  out  1  overflow flag
- un  out  1  underflow (tiny result) flag
- inexact  out  1  inexact flag

Behaviour:
- Three registered stages:
  - S1: unpack, special-case detect, exponent compare, swap, align shift.
  - S2: add/subtract, leading-zero normalise.
  - S3: round, pack, flags; S3 drives the outputs.
- Latency is exactly 3 cycles from the accept edge to out_valid, with no stalls.
- advance = !out_valid | out_ready. All stages, including valid bits, tag, round_m, and special-case bypass, move only when advance=1. in_ready = advance (combinational).
- Accept occurs when in_valid & in_ready. Bubbles propagate as valid=0. Throughput is 1 per cycle. Order is preserved.
- While out_valid=1 and out_ready=0: out, out_tag and flags hold stable, and nothing is accepted.
- Reset: asynchronous clear of every stage valid bit and pipeline register. out=0, out_tag=0, out_valid=0, all flags 0. in-flight operations are discarded. After release, the first accept is possible on the next edge.
- Decode:
  - exp=0 is zero/subnormal (implicit bit 0, effective exponent 1).
  - exp=all-ones with frac=0 is infinity.
  - frac!=0 with frac MSB=1 is qNaN; frac MSB=0 is sNaN.
- Datapath:
  - Significand is 1+FRAC_W bits plus guard, round, and sticky bits.
  - Align shift = exponent difference, saturated at FRAC_W+3; shifted-out bits OR into sticky.
  - Effective subtract when sign(A) != sign(B^sub). The larger magnitude is the minuend; result sign follows it.
  - Normalise left, stopping at effective exponent 1, so subnormals are produced. On carry-out, shift right by 1 and fold into sticky.
- Rounding (magnitude, sign s):
  - RNE: increment if G&(R|S|L).
  - RNA: increment if G.
  - RZ: truncate.
  - RU: increment if !s & (G|R|S).
  - RD: increment if s & (G|R|S).
  - Rounding carry renormalises; a subnormal rounding into min normal yields exp=1.
- Specials (flags not listed are 0):
  - Any NaN operand gives canonical qNaN: sign 0, exp all-ones, frac MSB only. inv=1 if either operand is sNaN.
  - inf - inf (effective subtract) gives canonical qNaN with inv=1.
  - inf op finite gives that infinity.
  - Same-sign infinities give that infinity.
- Exact zero result:
  - Opposite effective signs, including x-x: +0, except RD gives -0.
  - Both zeros with same effective sign keep that sign.
- Overflow: when the rounded exponent is >= all-ones, set ov=1 and inexact=1.
  - RNE/RNA: ±inf.
  - RZ: ±max finite.
  - RU: +inf, or -max finite for negative results.
  - RD: -inf, or +max finite for positive results.
- inexact = G|R|S after alignment/normalise, or overflow.
- un = 1 when the packed result is nonzero with exp field 0 (subnormal), independent of inexact.

Test Plan:
- Basic add: 0x3F800000 + 0x40000000, sub=0, RNE, tag=5, continuous out_ready -> out_valid exactly 3 cycles after accept; out=0x40400000, out_tag=5, all flags 0.
- Rounding at a tie: 0x3F800000 + 0x33800000:
  - RNE -> 0x3F800000, inexact=1.
  - RU -> 0x3F800001.
  - RNA -> 0x3F800001.
  - RD -> 0x3F800000.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF:
  - RNE -> 0x7F800000, ov=1, inexact=1.
  - RZ -> 0x7F7FFFFF, ov=1.
  - Negated operands with RU -> 0xFF7FFFFF.
- Specials:
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000, inv=1.
  - 0x7F800001 + 0x3F800000 -> 0x7FC00000, inv=1.
  - 0x7FC00001 + 1.0 -> 0x7FC00000, inv=0.
  - 0x3F800000 - 0x3F800000: RNE -> 0x00000000; RD -> 0x80000000.
- Subnormals:
  - 0x00000001 + 0x00000001 -> 0x00000002, un=1, inexact=0.
  - 0x00400000 + 0x00400000 -> 0x00800000, un=0.
  - 0x00800000 - 0x00000001 -> 0x007FFFFF, un=1.
- Back-pressure and reset:
  - Stream 6 operations with tags 0-5, out_ready held low for 5 cycles after the first out_valid -> in_ready=0 once 3 are in flight; out holds stable; all 6 results emerge in tag order with no loss or duplication.
  - Assert rst mid-stream -> out_valid=0 and all outputs 0 immediately, with no stale result after release.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined IEEE-754 add/subtract with subnormals, five rounding modes, tag pass-through and valid/ready back-pressure
// ports: clk, rst (async high); in_valid/in_ready/in_a/in_b/sub/round_m/in_tag request stream;
//        out_valid/out_ready/out/out_tag result stream with inv/ov/un/inexact flags
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] in_a,
  input  logic [EXP_W+FRAC_W:0] in_b,
  input  logic                  sub,
  input  logic [2:0]            round_m,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] out,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  inv,
  output logic                  ov,
  output logic                  un,
  output logic                  inexact
);
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 1;
  localparam int MW1 = FRAC_W + 2;
  localparam int XW = FRAC_W + 4;
  localparam int EW = EXP_W + 1;
  localparam int SAT = FRAC_W + 3;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] EMF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [2:0] RZ = 3'd1, RD = 3'd2, RU = 3'd3, RNA = 3'd4;
  logic adv;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  logic sa, sb, a_nan, b_nan, a_inf, b_inf, swap, sp, sp_inv;
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, diff;
  logic [MW-1:0] ma, mb, m_sml;
  logic [XW-1:0] ext, al;
  logic [31:0] sh;
  logic [W-1:0] sp_val;
  always_comb begin
    sa = in_a[W-1];
    sb = in_b[W-1] ^ sub;
    a_inf = (&in_a[W-2:FRAC_W]) & ~(|in_a[FRAC_W-1:0]);
    b_inf = (&in_b[W-2:FRAC_W]) & ~(|in_b[FRAC_W-1:0]);
    a_nan = (&in_a[W-2:FRAC_W]) & (|in_a[FRAC_W-1:0]);
    b_nan = (&in_b[W-2:FRAC_W]) & (|in_b[FRAC_W-1:0]);
    ea = in_a[W-2:FRAC_W] == '0 ? EXP_W'(1) : in_a[W-2:FRAC_W];
    eb = in_b[W-2:FRAC_W] == '0 ? EXP_W'(1) : in_b[W-2:FRAC_W];
    ma = {|in_a[W-2:FRAC_W], in_a[FRAC_W-1:0]};
    mb = {|in_b[W-2:FRAC_W], in_b[FRAC_W-1:0]};
    swap = in_b[W-2:0] > in_a[W-2:0];
    e_big = swap ? eb : ea;
    e_sml = swap ? ea : eb;
    m_sml = swap ? ma : mb;
    diff = e_big - e_sml;
    sh = 32'(diff) > 32'(SAT) ? 32'(SAT) : 32'(diff);
    ext = {m_sml, 3'b000};
    // bits shifted past the guard/round positions collapse into the sticky LSB
    al = (ext >> sh) | XW'(|(ext & ~({XW{1'b1}} << sh)));
    sp = a_nan | b_nan | a_inf | b_inf;
    sp_inv = (a_nan & ~in_a[FRAC_W-1]) | (b_nan & ~in_b[FRAC_W-1]) | (a_inf & b_inf & (sa ^ sb));
    sp_val = (a_nan | b_nan | (a_inf & b_inf & (sa ^ sb))) ? QNAN : {a_inf ? sa : sb, EMAX, {FRAC_W{1'b0}}};
  end
  logic v1, sp1, spi1, s1, sa1, eff1;
  logic [TAG_W-1:0] tag1;
  logic [2:0] rm1;
  logic [W-1:0] spv1;
  logic [EXP_W-1:0] e1;
  logic [MW-1:0] mb1;
  logic [XW-1:0] al1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v1, sp1, spi1, s1, sa1, eff1, tag1, rm1, spv1, e1, mb1, al1} <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      sp1 <= sp;
      spi1 <= sp_inv;
      spv1 <= sp_val;
      s1 <= swap ? sb : sa;
      sa1 <= sa;
      eff1 <= sa ^ sb;
      tag1 <= in_tag;
      rm1 <= round_m;
      e1 <= e_big;
      mb1 <= swap ? mb : ma;
      al1 <= al;
    end
  logic [XW:0] sum;
  logic [31:0] lz, nsh;
  logic [XW-1:0] nm;
  logic [EW-1:0] ne;
  always_comb begin
    sum = eff1 ? {1'b0, mb1, 3'b000} - {1'b0, al1} : {1'b0, mb1, 3'b000} + {1'b0, al1};
    lz = 32'(XW);
    for (int i = 0; i < XW; i++) lz = sum[i] ? 32'(XW - 1 - i) : lz;
    // left shift stops at effective exponent 1 so tiny results stay subnormal
    nsh = lz < 32'(e1) - 32'd1 ? lz : 32'(e1) - 32'd1;
    nm = sum[XW] ? {sum[XW:2], sum[1] | sum[0]} : sum[XW-1:0] << nsh;
    ne = sum[XW] ? EW'(e1) + EW'(1) : EW'(e1) - EW'(nsh);
  end
  logic v2, sp2, spi2, s2, sa2, eff2;
  logic [TAG_W-1:0] tag2;
  logic [2:0] rm2;
  logic [W-1:0] spv2;
  logic [EW-1:0] e2;
  logic [XW-1:0] m2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v2, sp2, spi2, s2, sa2, eff2, tag2, rm2, spv2, e2, m2} <= '0;
    end else if (adv) begin
      v2 <= v1;
      sp2 <= sp1;
      spi2 <= spi1;
      spv2 <= spv1;
      s2 <= s1;
      sa2 <= sa1;
      eff2 <= eff1;
      tag2 <= tag1;
      rm2 <= rm1;
      e2 <= ne;
      m2 <= nm;
    end
  logic l, g, r, st, grs, zero, rs, inc, hid, ovf, inf_r;
  logic [MW:0] rnd;
  logic [EW-1:0] er;
  logic [W-1:0] res;
  always_comb begin
    l = m2[3];
    g = m2[2];
    r = m2[1];
    st = m2[0];
    grs = g | r | st;
    zero = m2 == '0;
    rs = zero ? (eff2 ? rm2 == RD : sa2) : s2;
    inc = rm2 == RZ ? 1'b0 : rm2 == RU ? ~rs & grs : rm2 == RD ? rs & grs : rm2 == RNA ? g : g & (r | st | l);
    rnd = {1'b0, m2[XW-1:3]} + MW1'(inc);
    hid = rnd[MW] | rnd[MW-1];
    er = rnd[MW] ? e2 + EW'(1) : e2;
    ovf = hid & (er >= EW'(EMAX));
    inf_r = rm2 == RZ ? 1'b0 : rm2 == RU ? ~rs : rm2 == RD ? rs : 1'b1;
    res = ovf ? (inf_r ? {rs, EMAX, {FRAC_W{1'b0}}} : {rs, EMF, {FRAC_W{1'b1}}})
              : {rs, hid ? er[EXP_W-1:0] : {EXP_W{1'b0}}, rnd[MW] ? {FRAC_W{1'b0}} : rnd[FRAC_W-1:0]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {out_valid, out, out_tag, inv, ov, un, inexact} <= '0;
    end else if (adv) begin
      out_valid <= v2;
      out_tag <= tag2;
      out <= sp2 ? spv2 : res;
      inv <= sp2 & spi2;
      ov <= ~sp2 & ovf;
      un <= ~sp2 & ~hid & (|rnd);
      inexact <= ~sp2 & (grs | ovf);
    end
endmodule
